// File: rtl/atom_bus_pkg.sv
// atom_bus_pkg: shared state encoding, Atom control latch addresses and counter sizing.
package atom_bus_pkg;
   typedef enum logic [1:0] {IDLE, PH1, PH2, HOLD} state_t;
   localparam logic [15:0] ROMLATCH_ADDR = 16'hBFFF;
   localparam logic [15:0] SWLATCH_ADDR  = 16'hBFFE;
   localparam logic [15:0] JUMPER_ADDR   = 16'hBFFD;
   function automatic int cnt_width(input int a, input int b);
      return $clog2(a > b ? a : b) + 1;
   endfunction
endpackage

// File: rtl/atom_bus_if.sv
// atom_bus_if: host request/response handshake plus the 6502-style Atom bus pins.
interface atom_bus_if;
   logic        ReqValid;
   logic        ReqReady;
   logic [15:0] ReqAddr;
   logic        ReqWrite;
   logic [7:0]  ReqWData;
   logic        RspValid;
   logic [7:0]  RspData;
   logic [15:0] Addr;
   logic        RW;
   logic        PHI2;
   logic [7:0]  DataOut;
   logic        DataOE;
   logic [7:0]  DataIn;
   logic        Busy;
   modport master (
      input  ReqValid, ReqAddr, ReqWrite, ReqWData, DataIn,
      output ReqReady, RspValid, RspData, Addr, RW, PHI2, DataOut, DataOE, Busy
   );
   modport slave (
      output ReqValid, ReqAddr, ReqWrite, ReqWData, DataIn,
      input  ReqReady, RspValid, RspData, Addr, RW, PHI2, DataOut, DataOE, Busy
   );
endinterface

// File: rtl/atom_phase_timer.sv
// atom_phase_timer: loadable down-counter; tc flags the last cycle of the current phase.
module atom_phase_timer #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         NRESET,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);
   logic [W-1:0] cnt;
   assign tc = cnt == '0;
   always_ff @(posedge CLK or negedge NRESET)
      if (!NRESET) cnt <= '0;
      else cnt <= load ? load_val : (tc ? cnt : cnt - W'(1));
endmodule

// File: rtl/atom_bus_initiator.sv
// atom_bus_initiator: turns single host requests into registered PHI1/PHI2/HOLD Atom bus cycles.
module atom_bus_initiator import atom_bus_pkg::*; #(
   parameter int PHI1_CYCLES = 8,
   parameter int PHI2_CYCLES = 8
) (
   input logic        CLK,
   input logic        NRESET,
   atom_bus_if.master bus
);
   localparam int W = cnt_width(PHI1_CYCLES, PHI2_CYCLES);
   state_t state, state_n;
   logic [15:0] addr, addr_n;
   logic [7:0] dout, dout_n, rdata, rdata_n;
   logic rw, rw_n, phi2, phi2_n, oe, oe_n, rsp_v, rsp_v_n;
   logic load, tc;
   logic [W-1:0] load_val;
   atom_phase_timer #(.W(W)) u_timer (
      .CLK(CLK), .NRESET(NRESET), .load(load), .load_val(load_val), .tc(tc)
   );
   // The timer is loaded with length-1 so tc marks the final cycle of a phase.
   always_comb begin
      state_n = state;
      load = 1'b0;
      load_val = '0;
      addr_n = addr;
      rw_n = rw;
      dout_n = dout;
      oe_n = oe;
      phi2_n = 1'b0;
      rsp_v_n = 1'b0;
      rdata_n = rdata;
      case (state)
         IDLE: if (bus.ReqValid) begin
            state_n = PH1;
            load = 1'b1;
            load_val = W'(PHI1_CYCLES - 1);
            addr_n = bus.ReqAddr;
            rw_n = ~bus.ReqWrite;
            dout_n = bus.ReqWData;
         end
         PH1: if (tc) begin
            state_n = PH2;
            load = 1'b1;
            load_val = W'(PHI2_CYCLES - 1);
            phi2_n = 1'b1;
            oe_n = ~rw;
         end
         PH2: begin
            phi2_n = ~tc;
            if (tc) begin
               state_n = HOLD;
               load = 1'b1;
               rsp_v_n = 1'b1;
               rdata_n = rw ? bus.DataIn : rdata;
            end
         end
         HOLD: begin
            state_n = IDLE;
            load = 1'b1;
            rw_n = 1'b1;
            oe_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge NRESET)
      if (!NRESET) begin
         state <= IDLE;
         addr <= '0;
         rw <= 1'b1;
         dout <= '0;
         oe <= 1'b0;
         phi2 <= 1'b0;
         rsp_v <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_n;
         addr <= addr_n;
         rw <= rw_n;
         dout <= dout_n;
         oe <= oe_n;
         phi2 <= phi2_n;
         rsp_v <= rsp_v_n;
         rdata <= rdata_n;
      end
   assign bus.Addr = addr;
   assign bus.RW = rw;
   assign bus.DataOut = dout;
   assign bus.DataOE = oe;
   assign bus.PHI2 = phi2;
   assign bus.RspValid = rsp_v;
   assign bus.RspData = rdata;
   assign bus.ReqReady = state == IDLE;
   assign bus.Busy = state != IDLE;
endmodule

// File: tb/tb_atom_bus_initiator.sv
// tb_atom_bus_initiator: directed checks of bus timing, latch model, back-to-back and reset abort.
module tb_atom_bus_initiator;
   import atom_bus_pkg::*;
   logic CLK = 1'b0;
   logic NRESET = 1'b0;
   int passed = 0;
   int total = 0;
   logic [7:0] rom_latch = 8'h00;
   logic [7:0] sw_latch = 8'h00;
   logic [7:0] d1_in = 8'h00;
   localparam logic [37:0] RST_VEC = {16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

   atom_bus_if b0();
   atom_bus_if b1();
   atom_bus_initiator dut0 (.CLK(CLK), .NRESET(NRESET), .bus(b0.master));
   atom_bus_initiator #(.PHI1_CYCLES(1), .PHI2_CYCLES(1)) dut1 (.CLK(CLK), .NRESET(NRESET), .bus(b1.master));

   always #5 CLK = ~CLK;

   // RamRom latch model: writes during PHI2 high land in the addressed latch.
   always @(posedge CLK)
      if (b0.PHI2 && !b0.RW) begin
         if (b0.Addr == ROMLATCH_ADDR) rom_latch <= b0.DataOut;
         else if (b0.Addr == SWLATCH_ADDR) sw_latch <= b0.DataOut;
      end
   assign b0.DataIn = b0.Addr == ROMLATCH_ADDR ? rom_latch : b0.Addr == SWLATCH_ADDR ? sw_latch : 8'h3C;
   assign b1.DataIn = d1_in;

   function automatic logic [37:0] vec0();
      return {b0.Addr, b0.RW, b0.PHI2, b0.DataOut, b0.DataOE, b0.RspValid, b0.RspData, b0.ReqReady, b0.Busy};
   endfunction

   task automatic do_req(input logic [15:0] a, input logic w, input logic [7:0] wd, input logic tog,
                         output int rise_k, output int high_n, output int rsp_k, output int rsp_n,
                         output int bad_rwoe, output int bad_addr, output int bad_rdy, output logic [7:0] rdat);
      rise_k = 0; high_n = 0; rsp_k = 0; rsp_n = 0; bad_rwoe = 0; bad_addr = 0; bad_rdy = 0; rdat = 8'h00;
      b0.ReqAddr = a; b0.ReqWrite = w; b0.ReqWData = wd; b0.ReqValid = 1'b1;
      @(posedge CLK); #1;
      b0.ReqValid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (b0.PHI2) begin high_n++; if (rise_k == 0) rise_k = k; end
         if (b0.RspValid) begin rsp_n++; rsp_k = k; rdat = b0.RspData; end
         if (b0.Busy) begin
            if (b0.Addr !== a) bad_addr++;
            if (w ? (b0.RW !== 1'b0 || b0.DataOE !== (b0.PHI2 || b0.RspValid)) : (b0.RW !== 1'b1 || b0.DataOE !== 1'b0)) bad_rwoe++;
         end
         if (b0.ReqReady === b0.Busy) bad_rdy++;
         if (!b0.Busy) break;
         if (tog) begin b0.ReqValid = k[0] && !b0.RspValid; b0.ReqAddr = 16'h1000 + 16'(k); end
         @(posedge CLK); #1;
      end
      b0.ReqValid = 1'b0;
      b0.ReqAddr = a;
   endtask

   task automatic test_reset();
      total++; if (vec0() !== RST_VEC) $display("FAIL reset0 got %h want %h", vec0(), RST_VEC); else passed++;
      total++; if ({b1.Addr, b1.PHI2, b1.RspValid, b1.ReqReady, b1.Busy} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset1 got %h/%b%b%b%b want 0000/0010", b1.Addr, b1.PHI2, b1.RspValid, b1.ReqReady, b1.Busy); else passed++;
   endtask

   task automatic test_write_default();
      int rk, hn, sk, sn, bo, ba, br; logic [7:0] rd;
      do_req(ROMLATCH_ADDR, 1'b1, 8'h05, 1'b0, rk, hn, sk, sn, bo, ba, br, rd);
      total++; if (rk !== 9) $display("FAIL wr_phi2_rise got %0d want 9", rk); else passed++;
      total++; if (hn !== 8) $display("FAIL wr_phi2_high got %0d want 8", hn); else passed++;
      total++; if (sk !== 17) $display("FAIL wr_rsp_cycle got %0d want 17", sk); else passed++;
      total++; if (sn !== 1) $display("FAIL wr_rsp_count got %0d want 1", sn); else passed++;
      total++; if (bo !== 0) $display("FAIL wr_rw_oe got %0d bad cycles want 0", bo); else passed++;
      total++; if (ba !== 0) $display("FAIL wr_addr got %0d bad cycles want 0", ba); else passed++;
      total++; if (br !== 0) $display("FAIL wr_ready_busy got %0d bad cycles want 0", br); else passed++;
      total++; if (rom_latch !== 8'h05) $display("FAIL wr_romlatch got %h want 05", rom_latch); else passed++;
      total++; if (b0.RspData !== 8'h00) $display("FAIL wr_rspdata got %h want 00", b0.RspData); else passed++;
   endtask

   task automatic test_read_default();
      int rk, hn, sk, sn, bo, ba, br; logic [7:0] rd;
      do_req(ROMLATCH_ADDR, 1'b0, 8'hEE, 1'b0, rk, hn, sk, sn, bo, ba, br, rd);
      total++; if (sk !== 17) $display("FAIL rd_rsp_cycle got %0d want 17", sk); else passed++;
      total++; if (rd !== 8'h05) $display("FAIL rd_data got %h want 05", rd); else passed++;
      total++; if (bo !== 0) $display("FAIL rd_rw_oe got %0d bad cycles want 0", bo); else passed++;
      total++; if (hn !== 8) $display("FAIL rd_phi2_high got %0d want 8", hn); else passed++;
      repeat (5) @(posedge CLK);
      #1;
      total++; if (b0.RspData !== 8'h05) $display("FAIL rd_hold got %h want 05", b0.RspData); else passed++;
   endtask

   task automatic test_back_to_back();
      int acc_k = 0, rsp_j = 0, bad = 0;
      b0.ReqAddr = SWLATCH_ADDR; b0.ReqWrite = 1'b1; b0.ReqWData = 8'h08; b0.ReqValid = 1'b1;
      @(posedge CLK); #1;
      b0.ReqWrite = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (b0.ReqReady === b0.Busy) bad++;
         if (b0.ReqReady) begin acc_k = k; break; end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      b0.ReqValid = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         if (b0.ReqReady === b0.Busy) bad++;
         if (b0.RspValid) begin rsp_j = j; break; end
         @(posedge CLK); #1;
      end
      total++; if (acc_k !== 18) $display("FAIL b2b_accept_gap got %0d want 18", acc_k); else passed++;
      total++; if (rsp_j !== 17) $display("FAIL b2b_rsp_cycle got %0d want 17", rsp_j); else passed++;
      total++; if (b0.RspData !== 8'h08) $display("FAIL b2b_rdata got %h want 08", b0.RspData); else passed++;
      total++; if (sw_latch !== 8'h08) $display("FAIL b2b_swlatch got %h want 08", sw_latch); else passed++;
      total++; if (bad !== 0) $display("FAIL b2b_ready_busy got %0d bad cycles want 0", bad); else passed++;
      @(posedge CLK); #1;
   endtask

   task automatic test_fast_timing();
      int rk = 0, hn = 0, sk = 0, ba = 0; logic [7:0] rd = 8'h00;
      b1.ReqAddr = 16'h0A00; b1.ReqWrite = 1'b0; b1.ReqWData = 8'h00; d1_in = 8'hA5; b1.ReqValid = 1'b1;
      @(posedge CLK); #1;
      b1.ReqValid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (b1.PHI2) begin hn++; if (rk == 0) rk = k; end
         if (b1.RspValid) begin sk = k; rd = b1.RspData; end
         if (b1.Busy && (b1.Addr !== 16'h0A00 || b1.DataOE !== 1'b0)) ba++;
         if (!b1.Busy) break;
         @(posedge CLK); #1;
      end
      total++; if (hn !== 1) $display("FAIL fast_phi2_high got %0d want 1", hn); else passed++;
      total++; if (rk !== 2) $display("FAIL fast_phi2_rise got %0d want 2", rk); else passed++;
      total++; if (sk !== 3) $display("FAIL fast_rsp_cycle got %0d want 3", sk); else passed++;
      total++; if (rd !== 8'hA5) $display("FAIL fast_rdata got %h want A5", rd); else passed++;
      total++; if (ba !== 0) $display("FAIL fast_addr_oe got %0d bad cycles want 0", ba); else passed++;
   endtask

   task automatic test_reset_midcycle();
      logic saw = 1'b0; int extra = 0, bad = 0;
      b0.ReqAddr = 16'h6000; b0.ReqWrite = 1'b1; b0.ReqWData = 8'h77; b0.ReqValid = 1'b1;
      @(posedge CLK); #1;
      b0.ReqValid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (b0.PHI2 && b0.DataOE) begin saw = 1'b1; break; end
         @(posedge CLK); #1;
      end
      total++; if (saw !== 1'b1) $display("FAIL rst_reach_ph2 got %b want 1", saw); else passed++;
      repeat (3) @(posedge CLK);
      #2 NRESET = 1'b0;
      #1;
      total++; if (vec0() !== RST_VEC) $display("FAIL rst_async got %h want %h", vec0(), RST_VEC); else passed++;
      for (int k = 0; k < 2; k++) begin
         @(posedge CLK); #1;
         if (b0.Busy !== 1'b0 || b0.ReqReady !== 1'b1 || b0.RspValid !== 1'b0) bad++;
      end
      total++; if (bad !== 0) $display("FAIL rst_held got %0d bad cycles want 0", bad); else passed++;
      NRESET = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(posedge CLK); #1;
         if (b0.RspValid !== 1'b0 || b0.Busy !== 1'b0) extra++;
      end
      total++; if (extra !== 0) $display("FAIL rst_no_rsp got %0d active cycles want 0", extra); else passed++;
   endtask

   task automatic test_toggle_busy();
      int rk, hn, sk, sn, bo, ba, br, extra = 0; logic [7:0] rd;
      do_req(16'h0200, 1'b0, 8'h00, 1'b1, rk, hn, sk, sn, bo, ba, br, rd);
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         if (b0.RspValid !== 1'b0 || b0.Busy !== 1'b0) extra++;
      end
      total++; if (ba !== 0) $display("FAIL tog_addr got %0d bad cycles want 0", ba); else passed++;
      total++; if (sn !== 1) $display("FAIL tog_rsp_count got %0d want 1", sn); else passed++;
      total++; if (sk !== 17) $display("FAIL tog_rsp_cycle got %0d want 17", sk); else passed++;
      total++; if (rd !== 8'h3C) $display("FAIL tog_rdata got %h want 3C", rd); else passed++;
      total++; if (extra !== 0) $display("FAIL tog_extra got %0d active cycles want 0", extra); else passed++;
   endtask

   initial begin
      b0.ReqValid = 1'b0; b0.ReqAddr = 16'h0000; b0.ReqWrite = 1'b0; b0.ReqWData = 8'h00;
      b1.ReqValid = 1'b0; b1.ReqAddr = 16'h0000; b1.ReqWrite = 1'b0; b1.ReqWData = 8'h00;
      #12;
      test_reset();
      @(posedge CLK); #1;
      NRESET = 1'b1;
      @(posedge CLK); #1;
      test_write_default();
      test_read_default();
      test_back_to_back();
      test_fast_timing();
      test_reset_midcycle();
      test_toggle_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
